// File: rtl/led_sched_pkg.sv
// Shared types and elaboration helpers for the LED blink scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold a counter whose largest value is max_val (at least 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_prescaler.sv
// Free-running divide-by-DIV counter; TICK marks the terminal count, CLR restarts the period.
module tick_prescaler
  import led_sched_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  output logic TICK
);

  localparam int W = cnt_w(DIV - 1);

  logic [W-1:0] cnt_q;

  assign TICK = (cnt_q == W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (CLR || TICK) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the single LED: plays each granted pattern MSB-first, then an off gap, then ACK.
// Optional idle heartbeat on the LED is enabled with LED_SCHED_HEARTBEAT_EN.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ    = 16_000_000,
  parameter int TICK_HZ   = 8,
  parameter int NREQ      = 4,
  parameter int PAT_W     = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*PAT_W-1:0] PATTERN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       ACK,
  output logic                  BUSY,
  output logic                  LED,
  output logic                  USBPU
);

  localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int PW       = cnt_w(NREQ - 1);
  localparam int CW       = cnt_w(((PAT_W > GAP_TICKS) ? PAT_W : GAP_TICKS) - 1);

  if ((CLK_HZ % TICK_HZ) != 0 || TICK_DIV < 2) begin : g_bad_div
    $error("CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (NREQ < 2 || GAP_TICKS < 1) begin : g_bad_cfg
    $error("NREQ must be >= 2 and GAP_TICKS >= 1");
  end

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic            busy_q, busy_d, led_q, led_d;
  logic [PAT_W-1:0] sh_q, sh_d, pat_sel, sh_next;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   cur_q, cur_d, rr_q, rr_d, sel;
  logic [NREQ-1:0] sel_oh, cur_oh;
  logic            grant, tick, idle_led;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CLR  (grant),
    .TICK (tick)
  );

  // First requester at or above the round-robin pointer, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    sel     = rr_q;
    sel_oh  = '0;
    cur_oh  = '0;
    pat_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && REQ[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      sel_oh[i] = (sel == PW'(i));
      cur_oh[i] = (cur_q == PW'(i));
      if (sel == PW'(i)) pat_sel = PATTERN[i*PAT_W +: PAT_W];
    end
  end

  assign sh_next = sh_q << 1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    busy_d  = busy_q;
    led_d   = led_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    rr_d    = rr_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        led_d  = idle_led;
        if (|REQ) begin
          grant   = 1'b1;
          cur_d   = sel;
          gnt_d   = sel_oh;
          busy_d  = 1'b1;
          sh_d    = pat_sel;
          led_d   = pat_sel[PAT_W-1];
          cnt_d   = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (cnt_q == CW'(PAT_W - 1)) begin
            cnt_d   = '0;
            led_d   = 1'b0;
            state_d = GAP;
          end else begin
            sh_d  = sh_next;
            cnt_d = cnt_q + 1'b1;
            led_d = sh_next[PAT_W-1];
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt_q == CW'(GAP_TICKS - 1)) begin
            ack_d   = cur_oh;
            gnt_d   = '0;
            busy_d  = 1'b0;
            led_d   = idle_led;
            rr_d    = (cur_q == PW'(NREQ - 1)) ? '0 : cur_q + 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
    end
  end

`ifdef LED_SCHED_HEARTBEAT_EN
  // Heartbeat counts idle ticks only and keeps its phase across transactions.
  localparam int HW = cnt_w(TICK_HZ - 1);
  logic [HW-1:0] hb_cnt_q;
  logic          hb_q, hb_wrap;

  assign hb_wrap  = (state_q == IDLE) && tick && (hb_cnt_q == HW'(TICK_HZ - 1));
  assign idle_led = hb_wrap ? ~hb_q : hb_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (state_q == IDLE && tick) begin
      hb_cnt_q <= hb_wrap ? '0 : hb_cnt_q + 1'b1;
      hb_q     <= idle_led;
    end
  end
`else
  assign idle_led = 1'b0;
`endif

  assign GNT   = gnt_q;
  assign ACK   = ack_q;
  assign BUSY  = busy_q;
  assign LED   = led_q;
  assign USBPU = 1'b0;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler at TICK_DIV=4, NREQ=4, PAT_W=8, GAP_TICKS=2.
module tb_led_blink_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [31:0] PATTERN;
  logic [3:0]  GNT, ACK;
  logic        BUSY, LED, USBPU;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] pats;
    logic [3:0]  gnt;
    logic [7:0]  pat;
  } vec_t;

  vec_t vecs[7];

  led_blink_scheduler #(
    .CLK_HZ(16), .TICK_HZ(4), .NREQ(4), .PAT_W(8), .GAP_TICKS(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .PATTERN(PATTERN),
    .GNT(GNT), .ACK(ACK), .BUSY(BUSY), .LED(LED), .USBPU(USBPU)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called on the first GNT-high sample; checks 40 owned cycles and the ACK cycle.
  task automatic play_txn(input logic [3:0] g, input logic [7:0] p, input bit release_req,
                          input string tag);
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge CLK);
      check({tag, " led"}, 32'(LED), (j < 32) ? 32'(p[7 - j/4]) : 32'd0);
      if (j == 0 || j == 39) begin
        check({tag, " gnt"}, 32'(GNT), 32'(g));
        check({tag, " busy"}, 32'(BUSY), 32'd1);
        check({tag, " ack idle"}, 32'(ACK), 32'd0);
      end
      if (j == 1 && release_req) begin
        REQ     = 4'b0000;
        PATTERN = ~PATTERN;
      end
    end
    @(negedge CLK);
    check({tag, " ack"}, 32'(ACK), 32'(g));
    check({tag, " gnt off"}, 32'(GNT), 32'd0);
    check({tag, " busy off"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [3:0] acc;
    logic [3:0] order[5];
    RST_N   = 1'b0;
    REQ     = '0;
    PATTERN = '0;
    vecs[0] = '{4'b0001, {8'h11, 8'h22, 8'h33, 8'hA3}, 4'b0001, 8'hA3};
    vecs[1] = '{4'b0101, {8'h00, 8'h3C, 8'h00, 8'hFF}, 4'b0100, 8'h3C};
    vecs[2] = '{4'b0011, {8'h00, 8'h00, 8'hEE, 8'h00}, 4'b0001, 8'h00};
    vecs[3] = '{4'b1001, {8'h81, 8'h00, 8'h00, 8'h77}, 4'b1000, 8'h81};
    vecs[4] = '{4'b1110, {8'h12, 8'h34, 8'h5A, 8'h00}, 4'b0010, 8'h5A};
    vecs[5] = '{4'b0010, {8'h00, 8'h00, 8'hF0, 8'h00}, 4'b0010, 8'hF0};
    vecs[6] = '{4'b0100, {8'h00, 8'hC5, 8'h00, 8'h00}, 4'b0100, 8'hC5};

    repeat (3) @(negedge CLK);
    check("reset outs", {GNT, ACK, 2'b00, BUSY, LED}, 32'd0);
    RST_N = 1'b1;

    // Idle with no requests.
    acc = '0;
    begin
      int last_t, n_tog;
      logic prev;
      last_t = -1; n_tog = 0; prev = LED;
      for (int c = 0; c < 100; c++) begin
        @(negedge CLK);
        acc = acc | GNT | ACK | {3'b000, BUSY} | {3'b000, USBPU};
`ifdef LED_SCHED_HEARTBEAT_EN
        if (LED !== prev) begin
          if (last_t >= 0) check("heartbeat period", 32'(c - last_t), 32'd16);
          last_t = c;
          n_tog++;
        end
        prev = LED;
`else
        acc = acc | {3'b000, LED};
`endif
      end
`ifdef LED_SCHED_HEARTBEAT_EN
      check("heartbeat toggles", 32'(n_tog >= 5), 32'd1);
`endif
    end
    check("idle quiet", 32'(acc), 32'd0);

    // Table: arbitration, pattern playback, latching under input changes.
    for (int v = 0; v < 7; v++) begin
      @(negedge CLK);
      REQ     = vecs[v].req;
      PATTERN = vecs[v].pats;
      @(negedge CLK);
      play_txn(vecs[v].gnt, vecs[v].pat, 1'b1, $sformatf("vec%0d", v));
      @(negedge CLK);
      check($sformatf("vec%0d no regrant", v), {GNT, 3'b000, BUSY}, 32'd0);
    end

    // Reset during PLAY bit 3.
    @(negedge CLK);
    REQ     = 4'b0001;
    PATTERN = 32'h0000_00FF;
    @(negedge CLK);
    check("rst grant", 32'(GNT), 32'b0001);
    REQ = 4'b0000;
    repeat (12) @(negedge CLK);
    check("rst led before", 32'(LED), 32'd1);
    RST_N = 1'b0;
    #1;
    check("rst immediate", {GNT, ACK, 2'b00, BUSY, LED}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    acc = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      acc = acc | ACK | GNT | {3'b000, BUSY};
    end
    check("no ack after rst", 32'(acc), 32'd0);

    // All requesters held: strict rotation from requester 0, back-to-back.
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(negedge CLK);
    REQ     = 4'b1111;
    PATTERN = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      play_txn(order[k], 8'hFF, k == 4, $sformatf("rr%0d", k));
    end
    repeat (3) @(negedge CLK);
    check("final idle", {GNT, 3'b000, BUSY}, 32'd0);
    check("usbpu", 32'(USBPU), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
